// File: rtl/mcu_pwm_ramp_pkg.sv
// Shared constants, state encoding and target clamping for the PWM duty ramp controller.
package mcu_pwm_ramp_pkg;

    localparam int DUTY_W   = 7;
    localparam int DUTY_MAX = 100;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] t,
                                                     input logic [DUTY_W-1:0] max_duty);
        return (t > max_duty) ? max_duty : t;
    endfunction

endpackage

// File: rtl/mcu_pwm_ramp_tick.sv
// Interval counter: tick is high on the cycle where the count equals the interval.
module mcu_pwm_ramp_tick #(
    parameter int INT_W = 16
) (
    input  logic             mclk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [INT_W-1:0] interval,
    output logic             tick
);

    logic [INT_W-1:0] r_cnt;

    assign tick = (r_cnt == interval);

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= tick ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mcu_pwm_ramp.sv
// Duty slew controller: walks the PWM duty toward a clamped target in fixed steps.
// Handshake: start/abort are single-cycle strobes, abort wins; busy is high while ramping, done pulses once.
module mcu_pwm_ramp
    import mcu_pwm_ramp_pkg::*;
#(
    parameter int DUTY_MAX = mcu_pwm_ramp_pkg::DUTY_MAX,
    parameter int INT_W    = 16
) (
    input  logic             reset,
    input  logic             mclk,
    input  logic             start,
    input  logic             abort,
    input  logic [6:0]       target,
    input  logic [6:0]       step,
    input  logic [INT_W-1:0] interval,
    output logic [6:0]       duty,
    output logic             busy,
    output logic             done,
    output logic             o_dbg_state
);

    localparam logic [DUTY_W-1:0] L_MAX = DUTY_W'(DUTY_MAX);

    state_t             r_state;
    logic [DUTY_W-1:0]  r_duty;
    logic               r_done;
    logic [DUTY_W-1:0]  r_target;
    logic [DUTY_W-1:0]  r_step;
    logic [INT_W-1:0]   r_interval;

    state_t             w_state_nxt;
    logic [DUTY_W-1:0]  w_duty_nxt;
    logic               w_done_nxt;
    logic               w_latch;
    logic               w_clear;
    logic               w_tick;
    logic               w_start_ok;
    logic [DUTY_W-1:0]  w_tgt_in;
    logic [DUTY_W-1:0]  w_step_eff;
    logic               w_up;
    logic [DUTY_W:0]    w_diff;
    logic [DUTY_W-1:0]  w_step_duty;

    assign w_start_ok = start && !abort;
    assign w_tgt_in   = clamp_duty(target, L_MAX);

    // Distance is taken one bit wider so a step equal to the gap lands exactly on target.
    assign w_step_eff  = (r_step == '0) ? DUTY_W'(1) : r_step;
    assign w_up        = (r_target > r_duty);
    assign w_diff      = w_up ? ({1'b0, r_target} - {1'b0, r_duty})
                              : ({1'b0, r_duty} - {1'b0, r_target});
    assign w_step_duty = ({1'b0, w_step_eff} >= w_diff) ? r_target
                       : (w_up ? r_duty + w_step_eff : r_duty - w_step_eff);

    mcu_pwm_ramp_tick #(.INT_W(INT_W)) u_tick (
        .mclk     (mclk),
        .reset    (reset),
        .clear    (w_clear),
        .enable   (r_state == RAMP),
        .interval (r_interval),
        .tick     (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty;
        w_done_nxt  = 1'b0;
        w_latch     = 1'b0;
        w_clear     = (r_state == IDLE);
        if (r_state == IDLE) begin
            if (w_start_ok) begin
                w_latch = 1'b1;
                w_clear = 1'b1;
                if (w_tgt_in == r_duty) begin
                    w_done_nxt = 1'b1;
                end else begin
                    w_state_nxt = RAMP;
                end
            end
        end else begin
            if (abort) begin
                w_state_nxt = IDLE;
            end else if (start) begin
                w_latch = 1'b1;
                w_clear = 1'b1;
                if (w_tgt_in == r_duty) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end else if (w_tick) begin
                w_duty_nxt = w_step_duty;
                if (w_step_duty == r_target) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
        end
    end

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_duty     <= '0;
            r_done     <= 1'b0;
            r_target   <= '0;
            r_step     <= '0;
            r_interval <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_duty  <= w_duty_nxt;
            r_done  <= w_done_nxt;
            if (w_latch) begin
                r_target   <= w_tgt_in;
                r_step     <= step;
                r_interval <= interval;
            end
        end
    end

    assign duty        = r_duty;
    assign busy        = (r_state == RAMP);
    assign done        = r_done;
    assign o_dbg_state = r_state;

endmodule
